// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide request/response bundle.
// The master drives the operation request and the slave returns status and result.
interface ex_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             flush_i;
   logic             start_i;
   logic [2:0]       funct3_i;
   logic [WIDTH-1:0] op_a_i;
   logic [WIDTH-1:0] op_b_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             stall_o;

   modport master (
      output flush_i, start_i, funct3_i, op_a_i, op_b_i,
      input  busy_o, done_o, result_o, stall_o
   );

   modport slave (
      input  flush_i, start_i, funct3_i, op_a_i, op_b_i,
      output busy_o, done_o, result_o, stall_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, both run on operand magnitudes.
// Divide-by-zero and signed-overflow results skip the iteration entirely.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   ex_muldiv_unit_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [2:0]       r_f3;
   logic [WIDTH-1:0] r_opd;      // multiplicand magnitude (mul) or divisor magnitude (div)
   logic [WIDTH-1:0] r_hi;       // product high half (mul) or partial remainder (div)
   logic [WIDTH-1:0] r_lo;       // multiplier shifting out (mul) or dividend to quotient (div)
   logic             r_neg_q;    // negate product / quotient at the end
   logic             r_neg_r;    // negate remainder at the end
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic             w_sa, w_sb, w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic             w_b_zero, w_ovf, w_special;
   logic [WIDTH-1:0] w_special_res;
   logic [WIDTH:0]   w_sum, w_shift, w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_next_hi, w_next_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quo, w_rem, w_final;

   assign w_accept = bus.start_i & (r_state == S_IDLE) & ~bus.flush_i;

   // Decode signedness of the incoming op and detect results that need no iteration.
   always_comb begin
      w_sa     = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
      w_sb     = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
      w_a_neg  = w_sa & bus.op_a_i[WIDTH-1];
      w_b_neg  = w_sb & bus.op_b_i[WIDTH-1];
      w_mag_a  = w_a_neg ? -bus.op_a_i : bus.op_a_i;
      w_mag_b  = w_b_neg ? -bus.op_b_i : bus.op_b_i;
      w_b_zero = (bus.op_b_i == '0);
      w_ovf    = ~bus.funct3_i[0] & (bus.op_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                 & (bus.op_b_i == '1);
      w_special = bus.funct3_i[2] & (w_b_zero | w_ovf);
      if (w_b_zero)
         w_special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
      else
         w_special_res = bus.funct3_i[1] ? '0 : bus.op_a_i;
   end

   // One iteration step, plus the signed result the step would complete.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_opd};
      w_ge    = ~w_diff[WIDTH];
      if (r_f3[2]) begin
         w_next_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
         w_next_lo = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_next_hi = w_sum[WIDTH:1];
         w_next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
      end
      w_prod = r_neg_q ? -{w_next_hi, w_next_lo} : {w_next_hi, w_next_lo};
      w_quo  = r_neg_q ? -w_next_lo : w_next_lo;
      w_rem  = r_neg_r ? -w_next_hi : w_next_hi;
      case (r_f3)
         3'b000:                 w_final = w_prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: w_final = w_prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         w_final = w_quo;
         default:                w_final = w_rem;
      endcase
   end

   // Control FSM and datapath registers; flush returns to IDLE from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_f3     <= '0;
         r_opd    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (bus.flush_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_f3    <= bus.funct3_i;
                  r_opd   <= bus.funct3_i[2] ? w_mag_b : w_mag_a;
                  r_lo    <= bus.funct3_i[2] ? w_mag_a : w_mag_b;
                  r_hi    <= '0;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_cnt   <= '0;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_hi  <= w_next_hi;
               r_lo  <= w_next_lo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_result <= w_final;
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o   = (r_state == S_CALC) | (r_state == S_DONE);
   assign bus.done_o   = (r_state == S_DONE);
   assign bus.result_o = r_result;
   assign bus.stall_o  = w_accept | (r_state == S_CALC);

endmodule
